fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the FIFO's read port and shifts each byte out as an asynchronous UART frame. It sits directly downstream of the FIFO. It watches `empty`, pulses the FIFO's `read_en` once per byte, captures `data_out`, and drives a single `tx` line. The FIFO absorbs bursts from the write side, and this block paces them out at the configured bit rate.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per frame payload; must match the FIFO's `DATA_WIDTH`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.
- `CNT_SIZE`, 16: width of the bit-period counter; must hold `CLKS_PER_BIT-1`.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `tx_en`, input, 1: when high, new frames may start; when low, the current frame still completes.
- `fifo_empty`, input, 1: from FIFO `empty`.
- `fifo_data`, input, `DATA_WIDTH`: from FIFO `data_out`; valid the cycle after `read_en` is sampled high with `empty` low.
- `fifo_read_en`, output, 1: to FIFO `read_en`; registered single-cycle pulse.
- `tx`, output, 1: serial line; idles high.
- `tx_busy`, output, 1: high from the pop cycle through the last stop-bit cycle.

## Operation
- States: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE -> POP when `tx_en`=1 and `fifo_empty`=0. Otherwise stay in IDLE.
- POP: `fifo_read_en`=1 for exactly this cycle. Always goes to LOAD.
- LOAD: `fifo_data` is latched into the shift register, the bit counter is cleared, and the state goes to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `DATA_WIDTH` bits, LSB first, each held for `CLKS_PER_BIT` cycles.
  - The bit index counts 0..`DATA_WIDTH-1`.
  - After the last bit, go to PARITY (if compiled in) or STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- All outputs are registered. `tx_busy`=1 in every state except IDLE.
- `fifo_read_en` is never asserted while `fifo_empty`=1; the decision uses `fifo_empty` as sampled in IDLE.
- `fifo_data` is never sampled outside LOAD. Later FIFO activity does not corrupt a frame in flight.
- `tx_en` dropping mid-frame does not truncate the frame. The block stops in IDLE after the stop bit.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `fifo_read_en`=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame forces these values immediately. The byte being sent is lost and is not re-popped.
- Latency: if IDLE samples `fifo_empty`=0 in cycle N:
  - `fifo_read_en` is high in cycle N+1;
  - LOAD is in cycle N+2;
  - `tx` falls at the start of cycle N+3.
- Frame length: `(DATA_WIDTH+2)*CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` with parity.
- Back-to-back: when the FIFO is non-empty at the end of a stop bit, there are exactly 3 cycles of `tx`=1 (IDLE, POP, LOAD) after the stop-bit period, before the next start bit.
- Bit counter: counts 0..`CLKS_PER_BIT-1` and wraps to 0 on each bit boundary. There is no drift across frames.
- FIFO full on the write side has no effect on this block.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined:
  - The PARITY state is inserted between DATA and STOP.
  - `tx` carries the even-parity bit (XOR of the payload) for `CLKS_PER_BIT` cycles.
- Undefined: there is no PARITY state, and DATA goes directly to STOP.

## Test plan
- Reset with FIFO empty: `tx`=1, `tx_busy`=0, `fifo_read_en`=0, held for 100 cycles with no pop.
- `CLKS_PER_BIT`=4, push 0xA5:
  - `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles.
  - `fifo_read_en` is high for exactly one cycle.
  - Start bit falls 3 cycles after `fifo_empty` falls.
- Push 16 bytes 0x00..0x0F until the FIFO is full:
  - 16 frames are received in order.
  - There is a 3-cycle idle gap between frames.
  - There are exactly 16 `fifo_read_en` pulses, and none once `empty`=1.
- `tx_en`=0 midway through the third frame: the third frame completes intact, then the block stays in IDLE with the remaining bytes in the FIFO. Raising `tx_en` resumes with the fourth byte.
- Assert `reset` during DATA bit 3: `tx`=1 and `tx_busy`=0 within the same cycle. After release, the next FIFO byte is sent intact.
- With `FIFO_UART_TX_PARITY_EN`:
  - 0xA5 gives parity bit 0.
  - 0x07 gives parity bit 1.
  - Frame length is 44 cycles at `CLKS_PER_BIT`=4.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains a FIFO read port and shifts each byte out as an asynchronous UART
// frame: one start bit (0), DATA_WIDTH payload bits LSB first, an optional
// even-parity bit, and one stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> an even-parity bit (XOR of the payload) follows the data bits
//   undefined -> the data bits go straight to the stop bit
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   tx_en         in   allows a new frame to start; a frame in flight always
//                      completes
//   fifo_empty    in   FIFO empty flag
//   fifo_data     in   FIFO read data, valid the cycle after a pop
//   fifo_read_en  out  FIFO pop request, registered single-cycle pulse
//   tx            out  serial line, idles high
//   tx_busy       out  high in every state except IDLE
//   dbg_state     out  current FSM state, for observation only
//
// FIFO handshake: fifo_read_en is a one-cycle pop request. It is raised only
// when fifo_empty was seen low in IDLE, so the FIFO always honours it; the
// popped word appears on fifo_data in the following cycle (LOAD), which is the
// only cycle in which fifo_data is sampled.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_SIZE     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic [2:0]            dbg_state
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t                state, state_next;
    logic [CNT_SIZE-1:0]   clk_cnt, clk_cnt_next;
    logic [IDX_W-1:0]      bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  tx_next;
    logic                  read_en_next;
    logic                  busy_next;
    logic                  bit_done;

`ifdef FIFO_UART_TX_PARITY_EN
    logic parity_q, parity_next;
`endif

    // Last cycle of the current bit period.
    assign bit_done  = (clk_cnt == CNT_LAST);
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            fifo_read_en <= 1'b0;
        end else begin
            state        <= state_next;
            clk_cnt      <= clk_cnt_next;
            bit_idx      <= bit_idx_next;
            shift_reg    <= shift_next;
            tx           <= tx_next;
            tx_busy      <= busy_next;
            fifo_read_en <= read_en_next;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next  = parity_q;
`endif

        case (state)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_next = POP;
                end
            end

            POP: begin
                state_next = LOAD;
            end

            LOAD: begin
                shift_next   = fifo_data;
                clk_cnt_next = '0;
                bit_idx_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next  = ^fifo_data;
`endif
                state_next   = START;
            end

            START: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CNT_SIZE'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        // The line always shows shift_reg[0]; shifting brings
                        // the next payload bit into place.
                        bit_idx_next = bit_idx + IDX_W'(1);
                        shift_next   = shift_reg >> 1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_SIZE'(1);
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    state_next   = STOP;
                end else begin
                    clk_cnt_next = clk_cnt + CNT_SIZE'(1);
                end
            end
`endif

            STOP: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    clk_cnt_next = clk_cnt + CNT_SIZE'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
                bit_idx_next = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so each
        // output lines up with the state it belongs to.
        read_en_next = (state_next == POP);
        busy_next    = (state_next != IDLE);
        tx_next      = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx at CLKS_PER_BIT=4. A queue-based FIFO model feeds the
// DUT, a mid-bit sampling UART receiver decodes the line, and decoded bytes are
// compared against an expected queue of pushed bytes. Selected frames are also
// compared cycle by cycle against a waveform computed from the frame format.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int W = 8;
    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = (W + 2 + PAR) * C;
    localparam int DEPTH     = 16;

    // ---------------------------------------------------------------- clock/reset
    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         tx_en      = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data  = '0;
    logic         fifo_read_en;
    logic         tx;
    logic         tx_busy;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (W),
        .CLKS_PER_BIT(C),
        .CNT_SIZE    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_en       (tx_en),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .dbg_state   (dbg_state)
    );

    // ---------------------------------------------------------------- bookkeeping
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    logic [W-1:0] mem[$];
    logic [W-1:0] exp_q[$];
    int           pushes      = 0;
    int           pops        = 0;
    int           rd_pulses   = 0;
    int           frames      = 0;
    logic         prev_rd     = 1'b0;

    // receiver state
    logic         rx_active     = 1'b0;
    int           rx_t0         = 0;
    logic [W-1:0] rx_byte       = '0;
    int           prev_end      = 0;
    logic         have_prev_end = 1'b0;
    logic         prev_b2b      = 1'b0;

    // ---------------------------------------------------------------- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Line level expected at offset i after the cycle in which the byte became
    // visible: three idle-high cycles (IDLE, POP, LOAD), then the frame.
    function automatic logic exp_line(input logic [W-1:0] b, input int i);
        int p;
        if (i < 3) return 1'b1;
        p = (i - 3) / C;
        if (p == 0) return 1'b0;
        if (p <= W) return b[p-1];
        if (PAR == 1 && p == W + 1) return ^b;
        return 1'b1;
    endfunction

    // Mid-bit sampling receiver.
    task automatic rx_step();
        int           off;
        int           k;
        logic [W-1:0] want;
        if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_t0     = cyc;
                rx_byte   = '0;
                if (have_prev_end && prev_b2b) check("b2b_gap", cyc - prev_end - 1, 3);
            end
        end else begin
            off = cyc - rx_t0;
            if (off % C == C / 2) begin
                k    = off / C;
                want = (exp_q.size() > 0) ? exp_q[0] : '0;
                if (k == 0) begin
                    check("start_bit", tx, 1'b0);
                end else if (k <= W) begin
                    rx_byte[k-1] = tx;
                end else if (PAR == 1 && k == W + 1) begin
                    check("parity_bit", tx, ^want);
                end else begin
                    check("stop_bit", tx, 1'b1);
                    check("frame_expected", exp_q.size() > 0, 1'b1);
                    check("rx_byte", rx_byte, want);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    frames++;
                end
            end
            if (off == FRAME_LEN - 1) begin
                check("frame_end_high", tx, 1'b1);
                rx_active     = 1'b0;
                prev_end      = cyc;
                have_prev_end = 1'b1;
                prev_b2b      = tx_en && (mem.size() > 0);
            end
        end
    endtask

    // ---------------------------------------------------------------- drivers
    // One clock: sample the pop request before the edge, then update the FIFO
    // model and observe outputs 1 time unit after the edge.
    task automatic tick();
        logic rd_pre;
        logic emp_pre;
        @(negedge clk);
        rd_pre  = fifo_read_en;
        emp_pre = fifo_empty;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_pre) begin
            check("rd_while_empty", emp_pre, 1'b0);
            if (!emp_pre && mem.size() > 0) begin
                fifo_data = mem.pop_front();
                pops++;
            end
        end
        fifo_empty = (mem.size() == 0);
        if (fifo_read_en) begin
            rd_pulses++;
            check("rd_single_cycle", prev_rd, 1'b0);
        end
        prev_rd = fifo_read_en;
        check("busy_vs_state", (dbg_state != 3'd0), tx_busy);
        rx_step();
    endtask

    task automatic push_byte(input logic [W-1:0] b);
        if (mem.size() < DEPTH) begin
            mem.push_back(b);
            exp_q.push_back(b);
            pushes++;
            fifo_empty = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mem.size() != 0 || tx_busy || rx_active) && n < budget) begin
            tick();
            n++;
        end
        check(tag, n < budget, 1'b1);
    endtask

    // Cycle-exact frame check for a single byte pushed into an idle system.
    task automatic exact_frame(input logic [W-1:0] b);
        push_byte(b);
        for (int i = 0; i < FRAME_LEN + 6; i++) begin
            check("exact_tx", tx, exp_line(b, i));
            check("exact_rd_en", fifo_read_en, (i == 1));
            check("exact_busy", tx_busy, (i >= 1 && i < 3 + FRAME_LEN));
            tick();
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int           n;
        int           base_frames;
        int           base_rd;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset with the FIFO empty.
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_rd_en", fifo_read_en, 1'b0);
        reset = 1'b0;
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_tx", tx, 1'b1);
            check("idle_busy", tx_busy, 1'b0);
            check("idle_rd_en", fifo_read_en, 1'b0);
        end
        check("idle_no_pop", pops, 0);

        // Single frames, compared cycle by cycle.
        exact_frame(8'hA5);
        exact_frame(8'h07);
        check("exact_frames", frames, 2);

        // Burst of 16 bytes fills the FIFO; frames must come out in order with
        // the minimum idle gap between them.
        base_rd     = rd_pulses;
        base_frames = frames;
        for (int v = 0; v < 16; v++) push_byte(W'(v));
        check("burst_full", mem.size(), DEPTH);
        push_byte(8'hEE);
        wait_drain("burst_timeout", 16 * (FRAME_LEN + 3) + 100);
        check("burst_frames", frames - base_frames, 16);
        check("burst_rd_pulses", rd_pulses - base_rd, 16);

        // tx_en dropped in the middle of the third frame.
        base_frames = frames;
        for (int v = 0; v < 6; v++) push_byte(W'($urandom_range(0, 255)));
        n = 0;
        while (!(frames == base_frames + 2 && rx_active && (cyc - rx_t0) == FRAME_LEN / 2) && n < 2000) begin
            tick();
            n++;
        end
        check("txen_wait_timeout", n < 2000, 1'b1);
        tx_en = 1'b0;
        repeat (3 * FRAME_LEN) tick();
        check("txen_frames", frames - base_frames, 3);
        check("txen_left_in_fifo", mem.size(), 3);
        check("txen_idle_busy", tx_busy, 1'b0);
        check("txen_idle_tx", tx, 1'b1);
        tx_en = 1'b1;
        wait_drain("txen_timeout", 4 * (FRAME_LEN + 3) + 100);
        check("txen_resume_frames", frames - base_frames, 6);

        // Reset during data bit 3: the byte in flight is lost, the next one
        // is sent intact.
        base_frames = frames;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        push_byte(a);
        push_byte(b);
        n = 0;
        while (!(rx_active && (cyc - rx_t0) == 4 * C + 1) && n < 200) begin
            tick();
            n++;
        end
        check("rst_wait_timeout", n < 200, 1'b1);
        check("pre_rst_bit3", tx, a[3]);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_rd_en", fifo_read_en, 1'b0);
        rx_active     = 1'b0;
        have_prev_end = 1'b0;
        void'(exp_q.pop_front());
        tick();
        tick();
        reset = 1'b0;
        wait_drain("rst_timeout", 2 * (FRAME_LEN + 3) + 100);
        check("rst_after_frames", frames - base_frames, 1);

        // Random pushes at random times, overflowing the FIFO at times.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) push_byte(W'($urandom_range(0, 255)));
            tick();
        end
        wait_drain("rand_timeout", DEPTH * (FRAME_LEN + 3) + 200);

        // Totals: every accepted byte was popped exactly once; all but the
        // byte lost to reset appeared on the line.
        check("total_pops", pops, pushes);
        check("total_rd_pulses", rd_pulses, pushes);
        check("total_frames", frames, pushes - 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
